// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL supervision controller and the PLL / system-reset fabric.
// The master side is the controller; the slave side is the PLL, requester and reset consumers.
interface pll_reset_ctrl_if;
  logic       pwrdwn_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       sys_rst_n;
  logic       lock_timeout;
  logic [7:0] retry_count;

  modport master (
    input  pwrdwn_req,
    input  pll_locked,
    output pll_rst,
    output pll_pwrdwn,
    output sys_rst_n,
    output lock_timeout,
    output retry_count
  );

  modport slave (
    output pwrdwn_req,
    output pll_locked,
    input  pll_rst,
    input  pll_pwrdwn,
    input  sys_rst_n,
    input  lock_timeout,
    input  retry_count
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL power-up / lock supervisor: pulses PLL RST, qualifies LOCKED, releases the
// system reset and re-initialises the PLL on lock timeout or lock loss.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  pll_reset_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_PWRDN     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             pll_rst_q, pll_rst_d;
  logic             pll_pwrdwn_q, pll_pwrdwn_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_timeout_q, lock_timeout_d;
  logic [7:0]       retry_q, retry_d;
  logic             retry_inc;
  logic             lock_s;

  // LOCKED is asynchronous to the reference clock
  assign lock_s = sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_RESET;
      cnt_q          <= CNT_ZERO;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      pll_rst_q      <= 1'b1;
      pll_pwrdwn_q   <= 1'b0;
      sys_rst_n_q    <= 1'b0;
      lock_timeout_q <= 1'b0;
      retry_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync1_q        <= bus.pll_locked;
      sync2_q        <= sync1_q;
      pll_rst_q      <= pll_rst_d;
      pll_pwrdwn_q   <= pll_pwrdwn_d;
      sys_rst_n_q    <= sys_rst_n_d;
      lock_timeout_q <= lock_timeout_d;
      retry_q        <= retry_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lock_timeout_d = lock_timeout_q;
    retry_inc      = 1'b0;

    unique case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TO_LAST) begin
          state_d        = S_RESET;
          cnt_d          = CNT_ZERO;
          lock_timeout_d = 1'b1;
          retry_inc      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_d = CNT_ZERO;
        if (!lock_s) begin
          state_d   = S_RESET;
          retry_inc = 1'b1;
        end
      end
      S_PWRDN: begin
        cnt_d = CNT_ZERO;
        if (!bus.pwrdwn_req) state_d = S_RESET;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // power-down request pre-empts any transition decided above
    if (bus.pwrdwn_req) begin
      state_d        = S_PWRDN;
      cnt_d          = CNT_ZERO;
      lock_timeout_d = lock_timeout_q;
      retry_inc      = 1'b0;
    end

    retry_d = retry_q;
    if (retry_inc && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;

    // outputs registered from the next state so they change on the entering edge
    pll_rst_d    = (state_d == S_RESET) || (state_d == S_PWRDN);
    pll_pwrdwn_d = (state_d == S_PWRDN);
    sys_rst_n_d  = (state_d == S_RUN);
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.pll_pwrdwn   = pll_pwrdwn_q;
  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.lock_timeout = lock_timeout_q;
  assign bus.retry_count  = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with RST_PULSE=4, TIMEOUT=32, STABLE=8.
// Edge numbering: E1 is the first rising edge after reset_n is released.
module tb_pll_reset_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pll_reset_ctrl_if bus();

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .CNT_W              (17)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       req;
    logic       lock;
    logic       rst;
    logic       pd;
    logic       srn;
    logic       to;
    logic [7:0] rc;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [11:0] outs();
    return {bus.pll_rst, bus.pll_pwrdwn, bus.sys_rst_n, bus.lock_timeout, bus.retry_count};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got rst/pd/srn/to/rc=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                  name, act[11], act[10], act[9], act[8], act[7:0],
                  exp[11], exp[10], exp[9], exp[8], exp[7:0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold reset two edges, verify reset values, release just after an edge.
  task automatic do_reset(input logic lock);
    reset_n        = 1'b0;
    bus.pwrdwn_req = 1'b0;
    bus.pll_locked = lock;
    steps(2);
    check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    reset_n = 1'b1;
  endtask

  vec_t tbl[12];

  initial begin
    bus.pwrdwn_req = 1'b0;
    bus.pll_locked = 1'b0;

    // T1 lock-up, T5 power-down from RUN, T4 lock loss in RUN
    tbl[0]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // E1-3 RST pulse
    tbl[1]  = '{7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // E4-10 WAIT, no lock
    tbl[2]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // E11-20 sync+WAIT+STABLE
    tbl[3]  = '{5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // E21-25 RUN
    tbl[4]  = '{20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}; // E26-45 PWRDN
    tbl[5]  = '{4,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // E46-49 full pulse
    tbl[6]  = '{9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // E50-58 WAIT+STABLE
    tbl[7]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // E59-60 RUN
    tbl[8]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}; // E61-62 lock drop in sync
    tbl[9]  = '{4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}; // E63-66 re-init
    tbl[10] = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // E67-76 relock
    tbl[11] = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}; // E77-79 RUN again

    do_reset(1'b0);
    for (int v = 0; v < 12; v++) begin
      bus.pwrdwn_req = tbl[v].req;
      bus.pll_locked = tbl[v].lock;
      for (int k = 0; k < tbl[v].n; k++) begin
        step();
        check($sformatf("vec%0d_cyc%0d", v, k), outs(),
              {tbl[v].rst, tbl[v].pd, tbl[v].srn, tbl[v].to, tbl[v].rc});
        check($sformatf("invariant_vec%0d", v), {11'd0, bus.pll_rst & bus.sys_rst_n}, 12'd0);
      end
    end

    // T2: no lock ever -> timeout every 36 edges, sticky flag, saturating count
    do_reset(1'b0);
    steps(35);
    check("t2_before_timeout", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    step();  // E36
    check("t2_timeout", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    steps(3); // E39
    check("t2_pulse_last", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd1});
    step();  // E40
    check("t2_pulse_end", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
    steps(32); // E72
    check("t2_retry2", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd2});
    steps(36); // E108
    check("t2_retry3", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd3});
    steps(36 * 252); // E9180: 255th retry
    check("t2_retry255", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd255});
    steps(36 * 2);
    check("t2_saturate", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd255});

    // T3: lock_s low while STABLE count is 5; RUN only after 8 fresh lock cycles
    do_reset(1'b1);
    steps(8);                // E8
    bus.pll_locked = 1'b0;
    step();                  // E9 samples the glitch
    bus.pll_locked = 1'b1;
    step();                  // E10
    check("t3_stable_e10", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    step();                  // E11 back to WAIT
    check("t3_back_wait", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    steps(2);                // E13, undisturbed release point
    check("t3_no_early_release", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    steps(6);                // E19
    check("t3_last_stable", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    step();                  // E20
    check("t3_release", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});

    // T6: async reset mid-WAIT_LOCK with retry_count=2
    do_reset(1'b0);
    steps(77);               // E77: WAIT_LOCK cnt 1 after two retries
    check("t6_pre", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 8'd2});
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
